// File: rtl/pc_msg_deframer.sv
// Purpose: pops sync/header-framed words from a show-ahead FIFO and delivers MSG_WORDS-word messages to one of N_CH channels.
// Latency: header + MSG_WORDS pops at one word per cycle; ch_valid rises the cycle after the last payload pop.
// Backpressure: ch_valid/ch_msg hold until the addressed channel's ch_ready; no FIFO pops while a message is held.
//
// Ports:
//   CLK, RESET            sole clock, asynchronous active-low reset
//   pc_msg_valid/pc_msg   FIFO not-empty flag and show-ahead head word
//   pc_msg_ack            FIFO read enable (combinational), pops the head word this cycle
//   ch_valid/ch_ready     one-hot per-channel handshake
//   ch_msg                assembled payload, first popped word in the low slot
//   err_cnt               saturating count of sync, channel and timeout errors
//   busy                  high whenever the deframer is not waiting for a header
module pc_msg_deframer #(
  parameter int         XB_SIZE   = 32,
  parameter int         MSG_WORDS = 3,
  parameter int         N_CH      = 2,
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         TIMEOUT   = 1024,
  parameter int         DELAY     = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         pc_msg_valid,
  input  logic [XB_SIZE-1:0]           pc_msg,
  output logic                         pc_msg_ack,
  output logic [N_CH-1:0]              ch_valid,
  input  logic [N_CH-1:0]              ch_ready,
  output logic [MSG_WORDS*XB_SIZE-1:0] ch_msg,
  output logic [7:0]                   err_cnt,
  output logic                         busy
);

  localparam int IDX_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [8:0]       N_CH_W   = 9'(N_CH);

  // DELAY is kept so existing instantiations still elaborate; register timing
  // is not modelled here. The guard rejects parameter sets the logic can't handle.
  generate
    if (MSG_WORDS < 1 || N_CH < 1 || N_CH > 256 || TIMEOUT < 2 ||
        XB_SIZE < 16 || DELAY < 0) begin : g_bad_params
      $error("pc_msg_deframer: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DISCARD, S_HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [7:0]       ch_sel;

  logic sync_ok;
  logic ch_ok;
  logic last_word;
  logic hold_done;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Pops are never taken in HOLD, so a popped word is always consumed the same cycle.
  assign pc_msg_ack = RESET && pc_msg_valid && (state != S_HOLD);
  assign busy       = (state != S_HDR);
  assign sync_ok    = (pc_msg[XB_SIZE-1 -: 8] == SYNC);
  assign ch_ok      = ({1'b0, pc_msg[7:0]} < N_CH_W);
  assign last_word  = (idx == LAST_IDX);
  // ch_valid is one-hot on the latched channel, so other channels' ready bits drop out.
  assign hold_done  = |(ch_valid & ch_ready);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_HDR;
      idx      <= '0;
      timer    <= '0;
      ch_sel   <= '0;
      ch_valid <= '0;
      ch_msg   <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        S_HDR: begin
          timer <= '0;
          if (pc_msg_ack) begin
            idx <= '0;
            if (!sync_ok) begin
              // Drop one word and retry: resynchronises word by word.
              err_cnt <= sat_inc(err_cnt);
            end else if (ch_ok) begin
              ch_sel <= pc_msg[7:0];
              state  <= S_PAYLOAD;
            end else begin
              err_cnt <= sat_inc(err_cnt);
              state   <= S_DISCARD;
            end
          end
        end

        S_PAYLOAD, S_DISCARD: begin
          if (pc_msg_ack) begin
            timer <= '0;
            idx   <= idx + 1'b1;
            if (state == S_PAYLOAD) begin
              for (int k = 0; k < MSG_WORDS; k++) begin
                if (idx == IDX_W'(k)) ch_msg[k*XB_SIZE +: XB_SIZE] <= pc_msg;
              end
            end
            if (last_word) begin
              idx <= '0;
              if (state == S_PAYLOAD) begin
                state <= S_HOLD;
                for (int i = 0; i < N_CH; i++) ch_valid[i] <= (ch_sel == 8'(i));
              end else begin
                state <= S_HDR;
              end
            end
          end else if (timer == TMR_LAST) begin
            // Stalled partial frame: abandon it; the next frame rewrites every slot.
            err_cnt <= sat_inc(err_cnt);
            idx     <= '0;
            timer   <= '0;
            state   <= S_HDR;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_HOLD: begin
          if (hold_done) begin
            ch_valid <= '0;
            state    <= S_HDR;
          end
        end

        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_msg_deframer.sv
// Directed bench for pc_msg_deframer: a queue stands in for the show-ahead FIFO,
// popped whenever the DUT acks; expected values are hand-computed constants.
module tb_pc_msg_deframer;

  localparam int XB = 32;
  localparam int MW = 3;
  localparam int NC = 2;
  localparam logic [MW*XB-1:0] MSG_A = {32'h3C23D70A, 32'h00120000, 32'h00000140};

  logic              CLK;
  logic              RESET;
  logic              pc_msg_valid;
  logic [XB-1:0]     pc_msg;
  logic              pc_msg_ack;
  logic [NC-1:0]     ch_valid;
  logic [NC-1:0]     ch_ready;
  logic [MW*XB-1:0]  ch_msg;
  logic [7:0]        err_cnt;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XB-1:0] q[$];
  logic last_ack;
  logic [MW*XB-1:0] prev_msg;

  pc_msg_deframer #(
    .XB_SIZE(XB), .MSG_WORDS(MW), .N_CH(NC), .SYNC(8'hA5), .TIMEOUT(16), .DELAY(1)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .pc_msg_valid(pc_msg_valid), .pc_msg(pc_msg), .pc_msg_ack(pc_msg_ack),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_msg(ch_msg),
    .err_cnt(err_cnt), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic refresh();
    pc_msg_valid = (q.size() != 0);
    pc_msg       = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [XB-1:0] w);
    q.push_back(w);
    refresh();
  endtask

  task automatic push_frame(input logic [7:0] ch, input logic [XB-1:0] w0, w1, w2);
    push({8'hA5, 16'h0000, ch});
    push(w0);
    push(w1);
    push(w2);
  endtask

  // One clock: ack sampled mid-cycle, FIFO head popped just after the edge.
  task automatic step();
    @(negedge CLK);
    last_ack = pc_msg_ack;
    @(posedge CLK);
    #1;
    if (last_ack && q.size() != 0) void'(q.pop_front());
    refresh();
  endtask

  task automatic test_reset();
    RESET = 1'b0; ch_ready = '0; q.delete(); refresh();
    push(32'hA500_0000);
    #1;
    n_checks++; if (pc_msg_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", pc_msg_ack); end
    n_checks++; if (ch_valid !== 2'b00) begin n_fail++; $display("FAIL rst_ch_valid: got %b want 00", ch_valid); end
    n_checks++; if (ch_msg !== '0) begin n_fail++; $display("FAIL rst_ch_msg: got %h want 0", ch_msg); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    step(); step();
    q.delete(); refresh();
    RESET = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ch_ready = 2'b10;
    push_frame(8'd1, 32'h0000_0140, 32'h0012_0000, 32'h3C23_D70A);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (last_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack%0d: got %b want 1", i, last_ack); end
    end
    n_checks++; if (ch_valid !== 2'b10) begin n_fail++; $display("FAIL basic_valid: got %b want 10", ch_valid); end
    n_checks++; if (ch_msg !== MSG_A) begin n_fail++; $display("FAIL basic_msg: got %h want %h", ch_msg, MSG_A); end
    step();
    n_checks++; if (last_ack !== 1'b0) begin n_fail++; $display("FAIL basic_hold_ack: got %b want 0", last_ack); end
    n_checks++; if (ch_valid !== 2'b00) begin n_fail++; $display("FAIL basic_clear: got %b want 00", ch_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_hold();
    ch_ready = 2'b00;
    push_frame(8'd0, 32'h0000_0140, 32'h0012_0000, 32'h3C23_D70A);
    push_frame(8'd1, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (last_ack !== 1'b1) begin n_fail++; $display("FAIL hold_ack%0d: got %b want 1", i, last_ack); end
    end
    n_checks++; if (ch_valid !== 2'b01) begin n_fail++; $display("FAIL hold_valid: got %b want 01", ch_valid); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++; if (last_ack !== 1'b0) begin n_fail++; $display("FAIL hold_noack%0d: got %b want 0", i, last_ack); end
      n_checks++; if (ch_valid !== 2'b01) begin n_fail++; $display("FAIL hold_stable%0d: got %b want 01", i, ch_valid); end
      n_checks++; if (ch_msg !== MSG_A) begin n_fail++; $display("FAIL hold_msg%0d: got %h want %h", i, ch_msg, MSG_A); end
    end
    ch_ready = 2'b01;
    step();
    n_checks++; if (last_ack !== 1'b0) begin n_fail++; $display("FAIL hold_hs_ack: got %b want 0", last_ack); end
    n_checks++; if (ch_valid !== 2'b00) begin n_fail++; $display("FAIL hold_hs_clear: got %b want 00", ch_valid); end
    ch_ready = 2'b00;
    step();
    n_checks++; if (last_ack !== 1'b1) begin n_fail++; $display("FAIL hold_next_hdr: got %b want 1", last_ack); end
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (ch_valid !== 2'b10) begin n_fail++; $display("FAIL hold_f2_valid: got %b want 10", ch_valid); end
    n_checks++; if (ch_msg !== {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) begin n_fail++; $display("FAIL hold_f2_msg: got %h want cccc0003bbbb0002aaaa0001", ch_msg); end
    ch_ready = 2'b10;
    step();
    n_checks++; if (ch_valid !== 2'b00) begin n_fail++; $display("FAIL hold_f2_clear: got %b want 00", ch_valid); end
  endtask

  task automatic test_resync();
    ch_ready = 2'b10;
    push(32'h1234_5678);
    push_frame(8'd1, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303);
    step();
    n_checks++; if (last_ack !== 1'b1) begin n_fail++; $display("FAIL resync_ack: got %b want 1", last_ack); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL resync_err: got %0d want 1", err_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL resync_busy: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (ch_valid !== 2'b10) begin n_fail++; $display("FAIL resync_valid: got %b want 10", ch_valid); end
    n_checks++; if (ch_msg !== {32'h0303_0303, 32'h0202_0202, 32'h0101_0101}) begin n_fail++; $display("FAIL resync_msg: got %h want 030303030202020201010101", ch_msg); end
    step();
  endtask

  task automatic test_bad_channel();
    ch_ready = 2'b10;
    prev_msg = {32'h0303_0303, 32'h0202_0202, 32'h0101_0101};
    push(32'hA500_0007);
    push(32'hDEAD_0000); push(32'hDEAD_0001); push(32'hDEAD_0002);
    push_frame(8'd1, 32'h4444_0000, 32'h5555_0000, 32'h6666_0000);
    step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL badch_busy: got %b want 1", busy); end
    n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL badch_err: got %0d want 2", err_cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (last_ack !== 1'b1) begin n_fail++; $display("FAIL badch_ack%0d: got %b want 1", i, last_ack); end
      n_checks++; if (ch_valid !== 2'b00) begin n_fail++; $display("FAIL badch_novalid%0d: got %b want 00", i, ch_valid); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badch_done: got %b want 0", busy); end
    n_checks++; if (ch_msg !== prev_msg) begin n_fail++; $display("FAIL badch_msg_kept: got %h want %h", ch_msg, prev_msg); end
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (ch_valid !== 2'b10) begin n_fail++; $display("FAIL badch_next_valid: got %b want 10", ch_valid); end
    n_checks++; if (ch_msg !== {32'h6666_0000, 32'h5555_0000, 32'h4444_0000}) begin n_fail++; $display("FAIL badch_next_msg: got %h want 666600005555000044440000", ch_msg); end
    step();
  endtask

  task automatic test_timeout();
    ch_ready = 2'b10;
    push(32'hA500_0001);
    push(32'hBAD0_BAD0);
    step(); step();
    for (int i = 0; i < 15; i++) begin
      step();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_wait%0d: busy got %b want 1", i, busy); end
    end
    n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL tmo_early_err: got %0d want 2", err_cnt); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_abort: busy got %b want 0", busy); end
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL tmo_err: got %0d want 3", err_cnt); end
    push_frame(8'd1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (ch_valid !== 2'b10) begin n_fail++; $display("FAIL tmo_next_valid: got %b want 10", ch_valid); end
    n_checks++; if (ch_msg !== {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}) begin n_fail++; $display("FAIL tmo_next_msg: got %h want 333333332222222211111111", ch_msg); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    ch_ready = 2'b00;
    push(32'hA500_0001);
    push(32'h7777_0000);
    step(); step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
    push(32'h7777_0001);
    RESET = 1'b0;
    #1;
    n_checks++; if (ch_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_valid: got %b want 00", ch_valid); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_err: got %0d want 0", err_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (pc_msg_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", pc_msg_ack); end
    step();
    q.delete(); refresh();
    RESET = 1'b1;
    ch_ready = 2'b01;
    push_frame(8'd0, 32'h8888_0001, 32'h8888_0002, 32'h8888_0003);
    step();
    n_checks++; if (last_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_hdr_ack: got %b want 1", last_ack); end
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (ch_valid !== 2'b01) begin n_fail++; $display("FAIL rstmid_valid_after: got %b want 01", ch_valid); end
    n_checks++; if (ch_msg !== {32'h8888_0003, 32'h8888_0002, 32'h8888_0001}) begin n_fail++; $display("FAIL rstmid_msg: got %h want 888800038888000288880001", ch_msg); end
    step();
  endtask

  task automatic test_saturate();
    ch_ready = 2'b00;
    for (int i = 0; i < 300; i++) push(32'(i));
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) begin
        n_checks++; if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
      end
      if (i == 254) begin
        n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", err_cnt); end
      end
    end
    n_checks++; if (last_ack !== 1'b1) begin n_fail++; $display("FAIL sat_ack: got %b want 1", last_ack); end
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_busy: got %b want 0", busy); end
  endtask

  initial begin
    RESET = 1'b0;
    ch_ready = '0;
    pc_msg_valid = 1'b0;
    pc_msg = '0;
    last_ack = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_resync();
    test_bad_channel();
    test_timeout();
    test_reset_mid_frame();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
